gemm_tile_sequencer: RTL and testbench

GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

---
 rtl/gemm_tile_sequencer.sv | 174 +++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_sequencer.sv
// Walks a GEMM job as a sequence of N/M/K tiles, programming the accelerator
// registers for each tile and polling its full/done status over a simple bus.
module gemm_tile_sequencer #(
    parameter int          SUPER_SYS_ROWS = 16,
    parameter int          SUPER_SYS_COLS = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h9000_0000,
    parameter int          BLK_N          = SUPER_SYS_ROWS,
    parameter int          BLK_K          = SUPER_SYS_COLS,
    parameter int          BLK_M          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_m,
    input  logic [7:0]  cfg_k,
    input  logic [7:0]  cfg_n,
    input  logic [31:0] cfg_a_addr,
    input  logic [31:0] cfg_b_addr,
    input  logic [31:0] cfg_c_addr,
    output logic        busy,
    output logic        done,
    output logic [15:0] tile_count,
    output logic        system_bus_en,
    output logic        system_bus_rdwr,
    output logic [31:0] system_bus_addr,
    output logic [31:0] system_bus_wr_data,
    input  logic [31:0] system_bus_rd_data
);
    typedef enum logic [2:0] {IDLE, WRITE, FULL_WAIT, DONE_WAIT, FINISH} state_t;

    state_t      state;
    logic [7:0]  dim_m, dim_k, dim_n;
    logic [31:0] a_addr, b_addr, c_addr;
    logic [7:0]  idx_m, idx_k, idx_n;
    logic [2:0]  widx;
    logic [1:0]  poll_ph;

    logic [8:0]  m_end, k_end, n_end;
    logic [4:0]  msize, ksize, nsize;
    logic        first, last_k, last_m, last_n;
    logic [31:0] tile_a, tile_b, tile_c;
    logic [7:0]  wr_off;
    logic [31:0] wr_val;
    logic        unused_rd;

    assign unused_rd = ^system_bus_rd_data[31:1];

    assign m_end  = {1'b0, idx_m} + 9'(BLK_M);
    assign k_end  = {1'b0, idx_k} + 9'(BLK_K);
    assign n_end  = {1'b0, idx_n} + 9'(BLK_N);
    // Indices are always multiples of the block size, so the ragged edge is dim - idx.
    assign msize  = (m_end <= {1'b0, dim_m}) ? 5'(BLK_M) : 5'(dim_m - idx_m);
    assign ksize  = (k_end <= {1'b0, dim_k}) ? 5'(BLK_K) : 5'(dim_k - idx_k);
    assign nsize  = (n_end <= {1'b0, dim_n}) ? 5'(BLK_N) : 5'(dim_n - idx_n);
    assign first  = (idx_k == 8'd0);
    assign last_k = (k_end >= {1'b0, dim_k});
    assign last_m = (m_end >= {1'b0, dim_m});
    assign last_n = (n_end >= {1'b0, dim_n});

    assign tile_a = a_addr + 32'(idx_k) + 32'(idx_m) * 32'(dim_k);
    assign tile_b = b_addr + 32'(idx_n) + (32'(idx_k) + 32'(ksize) - 32'd1) * 32'(dim_n);
    assign tile_c = c_addr + 32'(idx_n) + 32'(idx_m) * 32'(dim_n);

    always_comb begin
        wr_off = 8'd0;
        wr_val = 32'd0;
        case (widx)
            3'd0: begin wr_off = 8'd12; wr_val = {24'd0, dim_k}; end
            3'd1: begin wr_off = 8'd16; wr_val = {24'd0, dim_n}; end
            3'd2: begin wr_off = 8'd0;  wr_val = tile_a; end
            3'd3: begin wr_off = 8'd4;  wr_val = tile_b; end
            3'd4: begin wr_off = 8'd8;  wr_val = tile_c; end
            3'd5: begin wr_off = 8'd20; wr_val = {30'd0, first, last_k}; end
            default: begin wr_off = 8'd24; wr_val = {17'd0, nsize, ksize, msize}; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            tile_count         <= 16'd0;
            system_bus_en      <= 1'b0;
            system_bus_rdwr    <= 1'b0;
            system_bus_addr    <= 32'd0;
            system_bus_wr_data <= 32'd0;
            dim_m <= 8'd0; dim_k <= 8'd0; dim_n <= 8'd0;
            a_addr <= 32'd0; b_addr <= 32'd0; c_addr <= 32'd0;
            idx_m <= 8'd0; idx_k <= 8'd0; idx_n <= 8'd0;
            widx    <= 3'd0;
            poll_ph <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    system_bus_en   <= 1'b0;
                    system_bus_rdwr <= 1'b0;
                    done            <= 1'b0;
                    busy            <= 1'b0;
                    // busy is still high during the done cycle, which blocks a same-cycle relaunch
                    if (start && !busy) begin
                        dim_m  <= cfg_m;      dim_k  <= cfg_k;      dim_n  <= cfg_n;
                        a_addr <= cfg_a_addr; b_addr <= cfg_b_addr; c_addr <= cfg_c_addr;
                        idx_m <= 8'd0; idx_k <= 8'd0; idx_n <= 8'd0;
                        widx       <= 3'd0;
                        tile_count <= 16'd0;
                        busy       <= 1'b1;
                        state      <= (cfg_m == 8'd0 || cfg_k == 8'd0 || cfg_n == 8'd0) ? FINISH : WRITE;
                    end
                end
                WRITE: begin
                    system_bus_en      <= 1'b1;
                    system_bus_rdwr    <= 1'b1;
                    system_bus_addr    <= BASE_ADDR + 32'(wr_off);
                    system_bus_wr_data <= wr_val;
                    if (widx == 3'd6) begin
                        tile_count <= tile_count + 16'd1;
                        poll_ph    <= 2'd0;
                        state      <= FULL_WAIT;
                    end else begin
                        widx <= widx + 3'd1;
                    end
                end
                FULL_WAIT: begin
                    system_bus_en   <= 1'b1;
                    system_bus_rdwr <= 1'b0;
                    system_bus_addr <= BASE_ADDR;
                    // ph0 presents the read, ph1 waits for the first reply, ph2 samples every cycle
                    if (poll_ph != 2'd2) begin
                        poll_ph <= poll_ph + 2'd1;
                    end else if (!system_bus_rd_data[0]) begin
                        system_bus_en <= 1'b0;
                        poll_ph       <= 2'd0;
                        widx          <= 3'd0;
                        if (last_k && last_m && last_n) begin
                            state <= DONE_WAIT;
                        end else begin
                            state <= WRITE;
                            if (!last_k) begin
                                idx_k <= idx_k + 8'(BLK_K);
                            end else begin
                                idx_k <= 8'd0;
                                if (!last_m) begin
                                    idx_m <= idx_m + 8'(BLK_M);
                                end else begin
                                    idx_m <= 8'd0;
                                    idx_n <= idx_n + 8'(BLK_N);
                                end
                            end
                        end
                    end
                end
                DONE_WAIT: begin
                    system_bus_en   <= 1'b1;
                    system_bus_rdwr <= 1'b0;
                    system_bus_addr <= BASE_ADDR + 32'd24;
                    if (poll_ph != 2'd2) begin
                        poll_ph <= poll_ph + 2'd1;
                    end else if (system_bus_rd_data[0]) begin
                        system_bus_en <= 1'b0;
                        state         <= FINISH;
                    end
                end
                FINISH: begin
                    system_bus_en   <= 1'b0;
                    system_bus_rdwr <= 1'b0;
                    done            <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Randomized and directed checks of gemm_tile_sequencer against a loop-level
// model of the tile register writes and a status-poll responder.
module tb_gemm_tile_sequencer;
    localparam logic [31:0] BASE = 32'h9000_0000;
    localparam int BLK = 16;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [7:0]  cfg_m = 8'd0, cfg_k = 8'd0, cfg_n = 8'd0;
    logic [31:0] cfg_a_addr = 32'd0, cfg_b_addr = 32'd0, cfg_c_addr = 32'd0;
    logic        busy, done, system_bus_en, system_bus_rdwr;
    logic [15:0] tile_count;
    logic [31:0] system_bus_addr, system_bus_wr_data, system_bus_rd_data;

    gemm_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_a_addr(cfg_a_addr), .cfg_b_addr(cfg_b_addr), .cfg_c_addr(cfg_c_addr),
        .busy(busy), .done(done), .tile_count(tile_count),
        .system_bus_en(system_bus_en), .system_bus_rdwr(system_bus_rdwr),
        .system_bus_addr(system_bus_addr), .system_bus_wr_data(system_bus_wr_data),
        .system_bus_rd_data(system_bus_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t e;
    int  n_cmp = 0, n_err = 0;
    int  exp_tc = 0, exp_tiles = 0;
    bit  job_active = 0, done_seen = 0, chk_en = 0, released = 0, done_ready = 0;
    int  full_polls = 0, done_polls = 0, full_cnt = 0, done_cnt = 0;
    logic [31:0] rsp;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h (%0d) want 0x%08h (%0d)", name, act, act, req, req);
        end
    endfunction

    function automatic wr_t mk(logic [31:0] off, logic [31:0] d);
        wr_t w;
        w.addr = BASE + off;
        w.data = d;
        return w;
    endfunction

    // Reference: every tile's register writes, straight from the loop nest.
    task automatic build_job(int m, int k, int n, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        exp_q.delete();
        exp_tiles = 0;
        for (int ni = 0; ni < n; ni += BLK)
            for (int mi = 0; mi < m; mi += BLK)
                for (int ki = 0; ki < k; ki += BLK) begin
                    int ns, ms, ks;
                    ns = (ni + BLK <= n) ? BLK : n % BLK;
                    ms = (mi + BLK <= m) ? BLK : m % BLK;
                    ks = (ki + BLK <= k) ? BLK : k % BLK;
                    exp_q.push_back(mk(12, 32'(k)));
                    exp_q.push_back(mk(16, 32'(n)));
                    exp_q.push_back(mk(0,  a + 32'(ki) + 32'(mi) * 32'(k)));
                    exp_q.push_back(mk(4,  b + 32'(ni) + 32'(ki + ks - 1) * 32'(n)));
                    exp_q.push_back(mk(8,  c + 32'(ni) + 32'(mi) * 32'(n)));
                    exp_q.push_back(mk(20, 32'((ki == 0) ? 2 : 0) + 32'((ki + BLK >= k) ? 1 : 0)));
                    exp_q.push_back(mk(24, 32'(ms + ks * 32 + ns * 1024)));
                    exp_tiles++;
                end
    endtask

    // Scoreboard: runs every cycle once reset is released.
    always @(negedge clk) if (chk_en) begin
        if (system_bus_en) begin
            check("bus_busy", busy, 1);
            check("bus_in_job", job_active && exp_tiles > 0, 1);
        end
        if (system_bus_en && system_bus_rdwr) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", system_bus_addr, system_bus_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (e.addr == BASE + 12 && exp_tc > 0) begin
                    check("full_released_before_write", released, 1);
                    released = 0;
                end
                check("wr_addr", system_bus_addr, e.addr);
                check("wr_data", system_bus_wr_data, e.data);
                if (e.addr == BASE + 24) exp_tc++;
            end
        end
        check("tile_count", tile_count, exp_tc);
        if (done) begin
            check("done_in_job", job_active, 1);
            check("done_after_writes", exp_q.size(), 0);
            check("done_after_ready", done_ready, 1);
            check("busy_at_done", busy, 1);
            done_seen  = 1;
            job_active = 0;
        end
    end

    // Status responder: reply lands on the cycle after the read is presented.
    initial begin
        system_bus_rd_data = 32'd0;
        forever begin
            @(negedge clk);
            rsp = $urandom;
            if (system_bus_en && system_bus_rdwr && system_bus_addr == BASE + 24) full_cnt = 0;
            if (system_bus_en && !system_bus_rdwr) begin
                if (system_bus_addr == BASE) begin
                    if (full_cnt < full_polls) begin rsp[0] = 1'b1; full_cnt++; end
                    else begin rsp[0] = 1'b0; released = 1; end
                end else if (system_bus_addr == BASE + 24) begin
                    if (done_cnt < done_polls) begin rsp[0] = 1'b0; done_cnt++; end
                    else begin rsp[0] = 1'b1; done_ready = 1; end
                end
            end
            @(posedge clk);
            #1 system_bus_rd_data = rsp;
        end
    end

    task automatic set_cfg(int m, int k, int n, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        cfg_m = 8'(m); cfg_k = 8'(k); cfg_n = 8'(n);
        cfg_a_addr = a; cfg_b_addr = b; cfg_c_addr = c;
    endtask

    task automatic launch_job(int m, int k, int n, logic [31:0] a, logic [31:0] b, logic [31:0] c, int fp, int dp);
        full_polls = fp;
        done_polls = dp;
        set_cfg(m, k, n, a, b, c);
        build_job(m, k, n, a, b, c);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        job_active = 1; done_seen = 0; released = 0; exp_tc = 0;
        full_cnt = 0; done_cnt = 0;
        done_ready = (exp_tiles == 0);
    endtask

    task automatic finish_job();
        int bound;
        bound = exp_tiles * (20 + full_polls) + done_polls + 50;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (done_seen) break;
        end
        check("done_seen", done_seen, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("final_tile_count", tile_count, exp_tiles);
        check("queue_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic run_job(int m, int k, int n, logic [31:0] a, logic [31:0] b, logic [31:0] c, int fp, int dp);
        launch_job(m, k, n, a, b, c, fp, dp);
        finish_job();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", system_bus_en, 0);
        check("rst_rdwr", system_bus_rdwr, 0);
        check("rst_addr", system_bus_addr, 0);
        check("rst_wdata", system_bus_wr_data, 0);
        check("rst_tile_count", tile_count, 0);
        @(posedge clk); #1 rst = 1'b1;
        chk_en = 1;

        // Pin the model with hand-computed values.
        build_job(16, 16, 16, 0, 256, 512);
        check("model1_size", exp_q.size(), 7);
        check("model1_k", exp_q[0].data, 16);
        check("model1_n", exp_q[1].data, 16);
        check("model1_a", exp_q[2].data, 0);
        check("model1_b", exp_q[3].data, 496);
        check("model1_c", exp_q[4].data, 512);
        check("model1_ctl", exp_q[5].data, 3);
        check("model1_dim", exp_q[6].data, 16912);
        build_job(20, 20, 20, 0, 400, 800);
        check("model2_tiles", exp_tiles, 8);
        check("model2_a", exp_q[51].data, 336);
        check("model2_b", exp_q[52].data, 796);
        check("model2_c", exp_q[53].data, 1136);
        check("model2_ctl", exp_q[54].data, 1);
        check("model2_dim", exp_q[55].data, 4228);
        check("model2_dim_addr", exp_q[55].addr, BASE + 24);
        exp_q.delete(); exp_tiles = 0;

        // Single tile, done after 5 polls.
        run_job(16, 16, 16, 0, 256, 512, 0, 5);
        check("single_tile_count", tile_count, 1);

        // Partial tiles.
        run_job(20, 20, 20, 0, 400, 800, 1, 2);
        check("partial_tile_count", tile_count, 8);

        // Backpressure: 10 busy polls per tile.
        run_job(20, 20, 20, 0, 400, 800, 10, 1);

        // Zero dimension: done two cycles after start, no bus activity.
        launch_job(16, 16, 0, 0, 256, 512, 0, 0);
        @(negedge clk);
        check("zero_busy_c1", busy, 1);
        check("zero_done_c1", done, 0);
        @(negedge clk);
        check("zero_done_c2", done, 1);
        @(negedge clk);
        check("zero_done_c3", done, 0);
        check("zero_busy_c3", busy, 0);
        check("zero_tile_count", tile_count, 0);
        repeat (3) @(posedge clk);

        // Start while busy: second pulse with new cfg must be ignored.
        launch_job(20, 20, 20, 100, 5000, 9000, 1, 1);
        repeat (25) @(posedge clk);
        #1 set_cfg(32, 48, 8, 7, 7, 7); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_job();
        repeat (20) @(posedge clk);

        // Reset during the 4th write of tile 2, then restart from tile 0.
        launch_job(20, 20, 20, 0, 400, 800, 0, 2);
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (system_bus_en && system_bus_rdwr && system_bus_addr == BASE + 4 && tile_count == 16'd2) begin
                hit = 1;
                break;
            end
        end
        check("rst_target_seen", hit, 1);
        rst = 1'b0; chk_en = 0;
        @(posedge clk); #1;
        check("midrst_en", system_bus_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_tile_count", tile_count, 0);
        rst = 1'b1;
        exp_q.delete(); exp_tc = 0; exp_tiles = 0; job_active = 0; done_seen = 0;
        chk_en = 1;
        repeat (20) @(posedge clk);
        check("no_done_after_reset", done_seen, 0);
        run_job(20, 20, 20, 0, 400, 800, 0, 2);

        // Address wrap and extreme K.
        run_job(1, 255, 17, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 1);

        // Randomized jobs.
        for (int j = 0; j < 10; j++)
            run_job($urandom_range(0, 40), $urandom_range(1, 40), $urandom_range(1, 40),
                    $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
